// File: rtl/alu_ctrl_md_if.sv
// EX-stage bus between the pipeline and the ALU control / multiply-divide block.
// The pipeline side drives decode fields and operands; the block returns control, stall and M-op result.
interface alu_ctrl_md_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            flush_i;
  logic [9:0]      funct_i;
  logic [1:0]      ALUOp_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [3:0]      ALUCtrl_o;
  logic            stall_o;
  logic [XLEN-1:0] md_result_o;
  logic            md_valid_o;

  modport master (
    output valid_i, flush_i, funct_i, ALUOp_i, rs1_i, rs2_i,
    input  ALUCtrl_o, stall_o, md_result_o, md_valid_o
  );

  modport slave (
    input  valid_i, flush_i, funct_i, ALUOp_i, rs1_i, rs2_i,
    output ALUCtrl_o, stall_o, md_result_o, md_valid_o
  );
endinterface

// File: rtl/alu_ctrl_md.sv
// ALU control decoder plus an iterative unsigned MUL/MULHU/DIVU/REMU sequencer.
// One radix-2 iteration per cycle; the result is strobed for a single cycle in DONE.
module alu_ctrl_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_ctrl_md_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2*XLEN-1:0] prod_r;
  logic [XLEN-1:0]   quo_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   opb_r;
  logic [2:0]        f3_r;
  logic [XLEN-1:0]   md_result_r;
  logic              md_valid_r;

  logic [6:0]        f7_s;
  logic [2:0]        f3_s;
  logic              f3_md_s;
  logic              is_md_s;
  logic [3:0]        alu_ctrl_s;
  logic              accept_s;
  logic              stall_s;
  logic              finish_s;
  logic [XLEN:0]     add_s;
  logic [2*XLEN-1:0] prod_step_s;
  logic [XLEN:0]     shift_s;
  logic [XLEN:0]     diff_s;
  logic [XLEN-1:0]   rem_step_s;
  logic [XLEN-1:0]   quo_step_s;
  logic [XLEN-1:0]   result_s;

  assign f7_s    = bus.funct_i[9:3];
  assign f3_s    = bus.funct_i[2:0];
  assign f3_md_s = (f3_s == 3'b000) || (f3_s == 3'b011) ||
                   (f3_s == 3'b101) || (f3_s == 3'b111);
  assign is_md_s = (bus.ALUOp_i == 2'b01) && f7_s[0] && !f7_s[5] && f3_md_s;

  // ALU control decode; rows are matched in priority order
  always_comb begin
    alu_ctrl_s = 4'b0000;
    if ((bus.ALUOp_i == 2'b01) && (f7_s == 7'd0) && (f3_s == 3'b100)) begin
      alu_ctrl_s = 4'b0001;
    end else if ((bus.ALUOp_i == 2'b01) && (f7_s == 7'd0) && (f3_s == 3'b001)) begin
      alu_ctrl_s = 4'b0010;
    end else if ((bus.ALUOp_i == 2'b01) && (f7_s == 7'd0) && (f3_s == 3'b000)) begin
      alu_ctrl_s = 4'b0011;
    end else if ((bus.ALUOp_i == 2'b01) && f7_s[5] && (f3_s == 3'b000)) begin
      alu_ctrl_s = 4'b0100;
    end else if ((bus.ALUOp_i == 2'b00) && (f3_s == 3'b000)) begin
      alu_ctrl_s = 4'b0110;
    end else if ((bus.ALUOp_i == 2'b00) && f7_s[5] && (f3_s == 3'b101)) begin
      alu_ctrl_s = 4'b0111;
    end else if ((bus.ALUOp_i == 2'b01) && f7_s[0] && f3_md_s) begin
      alu_ctrl_s = 4'b1000;
    end else begin
      alu_ctrl_s = 4'b0000;
    end
  end

  // One shift-add multiply step and one restoring divide step per cycle
  always_comb begin
    add_s       = {1'b0, prod_r[2*XLEN-1:XLEN]} + ({1'b0, opb_r} & {(XLEN+1){prod_r[0]}});
    prod_step_s = {add_s, prod_r[XLEN-1:1]};
    shift_s     = {rem_r, quo_r[XLEN-1]};
    diff_s      = shift_s - {1'b0, opb_r};
    // A set top bit means the trial subtraction went negative: restore
    if (diff_s[XLEN]) begin
      rem_step_s = shift_s[XLEN-1:0];
    end else begin
      rem_step_s = diff_s[XLEN-1:0];
    end
    quo_step_s = {quo_r[XLEN-2:0], ~diff_s[XLEN]};
    case (f3_r)
      3'b000:  result_s = prod_step_s[XLEN-1:0];
      3'b011:  result_s = prod_step_s[2*XLEN-1:XLEN];
      3'b101:  result_s = quo_step_s;
      3'b111:  result_s = rem_step_s;
      default: result_s = {XLEN{1'b0}};
    endcase
  end

  // Sequencer next-state and handshake decode
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    stall_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid_i && is_md_s && !bus.flush_i) begin
          accept_s = 1'b1;
          stall_s  = 1'b1;
          state_s  = ST_BUSY;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (bus.flush_i) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          finish_s = 1'b1;
          state_s  = ST_DONE;
        end else begin
          state_s  = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch and iteration registers; a flush leaves them untouched
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r  <= {CNT_W{1'b0}};
      prod_r <= {(2*XLEN){1'b0}};
      quo_r  <= {XLEN{1'b0}};
      rem_r  <= {XLEN{1'b0}};
      opb_r  <= {XLEN{1'b0}};
      f3_r   <= 3'b000;
    end else if (accept_s) begin
      cnt_r  <= CNT_W'(XLEN);
      prod_r <= {{XLEN{1'b0}}, bus.rs1_i};
      quo_r  <= bus.rs1_i;
      rem_r  <= {XLEN{1'b0}};
      opb_r  <= bus.rs2_i;
      f3_r   <= f3_s;
    end else if ((state_r == ST_BUSY) && !bus.flush_i) begin
      cnt_r  <= cnt_r - CNT_W'(1);
      prod_r <= prod_step_s;
      quo_r  <= quo_step_s;
      rem_r  <= rem_step_s;
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Result register and strobe, loaded from the final iteration so they land in DONE
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      md_result_r <= {XLEN{1'b0}};
      md_valid_r  <= 1'b0;
    end else begin
      md_valid_r <= finish_s;
      if (finish_s) begin
        md_result_r <= result_s;
      end
    end
  end

  assign bus.ALUCtrl_o   = alu_ctrl_s;
  assign bus.stall_o     = stall_s;
  assign bus.md_result_o = md_result_r;
  assign bus.md_valid_o  = md_valid_r;

endmodule

// File: doc/alu_ctrl_md.md
Name: alu_ctrl_md

Overview:
Second-generation ALU control for the pipelined CPU. It decodes funct7/funct3 (10-bit funct_i) and ALUOp into an extended 4-bit ALU control code, and adds an iterative XLEN-parametrised unsigned multiply/divide sequencer for the M-extension subset MUL, MULHU, DIVU and REMU. It sits in EX beside the ALU, holds the pipeline via stall_o while an M-op runs, and returns the M-op result on a one-cycle valid pulse.

Parameters:
XLEN, 32, operand/result width (>=4, even)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
valid_i  in  1  EX-stage instruction valid
flush_i  in  1  squash EX instruction; aborts a running M-op
funct_i  in  10  {funct7, funct3}; bit 8 = funct7[5], bit 3 = funct7[0]
ALUOp_i  in  2  01 = R-type, 00 = I/load/store
rs1_i  in  XLEN  operand A / dividend
rs2_i  in  XLEN  operand B / divisor
ALUCtrl_o  out  4  ALU control code (combinational)
stall_o  out  1  hold IF/ID/EX
md_result_o  out  XLEN  M-op result
md_valid_o  out  1  one-cycle result strobe

Behaviour:
- Reset (rst_i=0, async): state=IDLE, counter=0, product/quotient/remainder regs=0, md_result_o=0, md_valid_o=0, stall_o=0.
- Decode (combinational, every cycle):
  - ALUOp=01, f7=0, f3=100: 0001 XOR
  - ALUOp=01, f7=0, f3=001: 0010 SLL
  - ALUOp=01, f7=0, f3=000: 0011 ADD
  - ALUOp=01, f7[5]=1, f3=000: 0100 SUB
  - ALUOp=00, f3=000: 0110 ADDI/LW/SW
  - ALUOp=00, f7[5]=1, f3=101: 0111 SRAI
  - ALUOp=01, f7[0]=1, f3 in {000,011,101,111}: 1000 MD (take md_result_o)
  - anything else: 0000
- is_md = ALUOp=01 and f7[0]=1 and funct7[5]=0 and f3 in {000 MUL, 011 MULHU, 101 DIVU, 111 REMU}.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if valid_i & is_md & !flush_i -> latch rs1/rs2/f3, counter=XLEN, go BUSY. stall_o=1 combinationally in this accept cycle.
  - BUSY: stall_o=1; one iteration per cycle; counter decrements; at counter==1 go DONE. flush_i=1 -> IDLE, no strobe, regs keep values.
  - DONE: md_valid_o=1 and md_result_o valid for exactly this cycle; stall_o=0; unconditionally go IDLE. valid_i is not accepted in DONE, since the held instruction is the one completing.
- Latency: accept at cycle T; BUSY T+1..T+XLEN; DONE/md_valid_o at T+XLEN+1. stall_o high T..T+XLEN.
- MUL/MULHU: radix-2 shift-add into a 2*XLEN product register, unsigned. MUL -> low XLEN bits; MULHU -> high XLEN bits.
- DIVU/REMU: restoring division with an XLEN+1-bit partial remainder.
  - Divisor==0: quotient = all ones, remainder = rs1 (RISC-V rule). Full XLEN latency is still taken.
- md_result_o holds its last value outside DONE. md_valid_o is never high in two consecutive cycles.
- flush_i in IDLE together with valid_i & is_md: no accept, stall_o=0.
- rst_i low mid-operation: immediate return to reset values, no strobe.
- Non-MD instructions never assert stall_o.

Test Plan:
- Reset mid-BUSY (rst_i low at T+5) -> stall_o=0, md_valid_o=0 immediately; IDLE after release.
- Decode sweep: ALUOp=01, funct_i=10'h000 -> 0011; 10'h100 -> 0100; 10'h004 -> 0001; 10'h001 -> 0010; ALUOp=00, 10'h105 -> 0111; ALUOp=01, 10'h008 -> 1000; ALUOp=01, 10'h00A -> 0000.
- MUL 7x6, XLEN=32, accept at T -> stall_o high T..T+32; md_valid_o at T+33 with md_result_o=42. MULHU FFFFFFFF x FFFFFFFF -> FFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> FFFFFFFF; REMU 5/0 -> 5.
- flush_i at T+10 of DIVU -> IDLE at T+11, stall_o=0, no md_valid_o; next MUL 3x3 -> 9 after a full 33 cycles.
- XLEN=8 instance: MUL 0xFF x 0xFF -> 0x01, MULHU -> 0xFE; md_valid_o at T+9; back-to-back M-ops keep valid_i held through DONE, accepting the second at DONE+1.
